// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Fetch sequencer; single outstanding SRAM-like request, stale-response
//            discard, output buffer + skid. Optional macro: FETCH_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall_if,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst,
   output logic        fetch_available,
   output logic [31:0] perf_req_cnt,
   output logic [31:0] perf_drop_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q;
   logic        cancel_q, cancel_d;
   logic        fetch_valid_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] fetch_inst_q;
   logic        skid_valid_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_inst_q;
   logic        avail_q;

   logic        w_redirect;
   logic [31:0] w_redirect_pc;
   logic        w_issue_ok;
   logic        w_handshake;
   logic        w_resp;
   logic        w_drop;
   logic        w_capture;
   logic        w_room;
   logic        w_consume;

   assign w_redirect    = flush | br_taken;
   assign w_redirect_pc = flush ? flush_pc : br_target;
   assign w_room        = !fetch_valid_q || !stall_if;
   assign w_consume     = fetch_valid_q && !stall_if;
   assign w_issue_ok    = !skid_valid_q && w_room;
   assign w_handshake   = inst_req && inst_addr_ok;
   assign w_resp        = (state_q == S_WAIT) && inst_data_ok;
   // A response is stale if an earlier redirect marked it, or a redirect lands with it.
   assign w_drop        = w_resp && (cancel_q || w_redirect);
   assign w_capture     = w_resp && !w_drop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   if (w_handshake)  state_d = S_WAIT;
         S_WAIT:  if (inst_data_ok) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inst_req  = 1'b0;
      inst_addr = 32'd0;
      if ((state_q == S_REQ) && w_issue_ok) begin
         inst_req  = 1'b1;
         inst_addr = pc_q;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (w_capture) pc_d = req_pc_q + PC_STEP;
      if (w_redirect) pc_d = w_redirect_pc;
   end

   // Only one response can be in flight, so one cancel bit covers every redirect.
   always_comb begin
      cancel_d = cancel_q;
      if (w_resp) begin
         cancel_d = 1'b0;
      end else if (w_redirect && ((state_q == S_WAIT) || w_handshake)) begin
         cancel_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_q     <= RESET_PC;
         req_pc_q <= 32'd0;
         cancel_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         cancel_q <= cancel_d;
         if (w_handshake) req_pc_q <= pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_valid_q <= 1'b0;
         fetch_pc_q    <= 32'd0;
         fetch_inst_q  <= 32'd0;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= 32'd0;
         skid_inst_q   <= 32'd0;
         avail_q       <= 1'b0;
      end else begin
         avail_q <= w_capture;
         if (w_redirect) begin
            fetch_valid_q <= 1'b0;
            skid_valid_q  <= 1'b0;
         end else if (w_capture && w_room) begin
            fetch_valid_q <= 1'b1;
            fetch_pc_q    <= req_pc_q;
            fetch_inst_q  <= inst_rdata;
         end else if (w_capture) begin
            // Issue is blocked while the skid is full, so it is always empty here.
            skid_valid_q  <= 1'b1;
            skid_pc_q     <= req_pc_q;
            skid_inst_q   <= inst_rdata;
         end else if (w_consume) begin
            if (skid_valid_q) begin
               fetch_pc_q    <= skid_pc_q;
               fetch_inst_q  <= skid_inst_q;
               skid_valid_q  <= 1'b0;
            end else begin
               fetch_valid_q <= 1'b0;
            end
         end
      end
   end

   assign fetch_valid     = fetch_valid_q;
   assign fetch_pc        = fetch_pc_q;
   assign fetch_inst      = fetch_inst_q;
   assign fetch_available = avail_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_req_q;
   logic [31:0] perf_drop_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_req_q  <= 32'd0;
         perf_drop_q <= 32'd0;
      end else begin
         if (w_handshake) perf_req_q  <= perf_req_q + 32'd1;
         if (w_drop)      perf_drop_q <= perf_drop_q + 32'd1;
      end
   end

   assign perf_req_cnt  = perf_req_q;
   assign perf_drop_cnt = perf_drop_q;
`else
   assign perf_req_cnt  = 32'd0;
   assign perf_drop_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Randomized bench for if_fetch_ctrl against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        stall_if = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'd0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'd0;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        fetch_available;
   logic [31:0] perf_req_cnt;
   logic [31:0] perf_drop_cnt;

   if_fetch_ctrl dut (
      .clk(clk), .resetn(resetn), .stall_if(stall_if),
      .flush(flush), .flush_pc(flush_pc), .br_taken(br_taken), .br_target(br_target),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .fetch_available(fetch_available),
      .perf_req_cnt(perf_req_cnt), .perf_drop_cnt(perf_drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Bus slave: remembers the accepted address and returns its word later.
   bit          slv_pend = 0;
   logic [31:0] slv_addr = 32'd0;
   logic [31:0] hs_log[$];
   int          p_aok = 100, p_dok = 100, p_stall = 0, p_redir = 0;
   bit          hold_data = 0;

   always @(negedge clk) begin
      if (!resetn) begin
         slv_pend = 0;
      end else begin
         if (inst_data_ok) slv_pend = 0;
         if (inst_req && inst_addr_ok) begin
            slv_pend = 1;
            slv_addr = inst_addr;
            hs_log.push_back(inst_addr);
         end
      end
   end

   task automatic drive_random();
      stall_if     = ($urandom_range(99) < p_stall);
      inst_addr_ok = ($urandom_range(99) < p_aok);
      if (slv_pend && !hold_data && ($urandom_range(99) < p_dok)) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem_word(slv_addr);
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = $urandom;
      end
      flush     = ($urandom_range(999) < p_redir);
      br_taken  = ($urandom_range(999) < p_redir);
      flush_pc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      br_target = $urandom;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_random();
   endtask

   // Behavioural model: buffer+skid as a queue, one pending response with a stale flag.
   bit          m_valid = 0;
   int          m_phase = 0;      // 0 post-reset idle, 1 may request, 2 awaiting data
   logic [31:0] m_pc, m_req_pc;
   bit          m_stale, m_avail;
   logic [31:0] m_qpc[$];
   logic [31:0] m_qinst[$];
   logic [31:0] m_nreq, m_ndrop;
   bit          m_issue, m_redir, m_cap;
   logic [31:0] m_tgt;

   always @(negedge clk) begin
      m_issue = (m_phase == 1) && (m_qpc.size() < 2) && (m_qpc.size() == 0 || !stall_if);
      if (m_valid) begin
         chk("inst_req", {31'd0, inst_req}, {31'd0, m_issue});
         if (m_issue) chk("inst_addr", inst_addr, m_pc);
         chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_qpc.size() > 0});
         if (m_qpc.size() > 0) begin
            chk("fetch_pc", fetch_pc, m_qpc[0]);
            chk("fetch_inst", fetch_inst, m_qinst[0]);
         end
         chk("fetch_available", {31'd0, fetch_available}, {31'd0, m_avail});
`ifdef FETCH_PERF_CNT_EN
         chk("perf_req_cnt", perf_req_cnt, m_nreq);
         chk("perf_drop_cnt", perf_drop_cnt, m_ndrop);
`else
         chk("perf_req_cnt", perf_req_cnt, 32'd0);
         chk("perf_drop_cnt", perf_drop_cnt, 32'd0);
`endif
      end
      if (!resetn) begin
         m_valid = 1;
         m_phase = 0;
         m_pc    = RESET_PC;
         m_req_pc = 32'd0;
         m_stale = 0;
         m_avail = 0;
         m_qpc.delete();
         m_qinst.delete();
         m_nreq  = 32'd0;
         m_ndrop = 32'd0;
      end else if (m_valid) begin
         m_redir = flush || br_taken;
         m_tgt   = flush ? flush_pc : br_target;
         m_cap   = 0;
         if (m_qpc.size() > 0 && !stall_if) begin
            void'(m_qpc.pop_front());
            void'(m_qinst.pop_front());
         end
         case (m_phase)
            0: m_phase = 1;
            1: if (m_issue && inst_addr_ok) begin
                  m_req_pc = m_pc;
                  m_phase  = 2;
                  m_nreq   = m_nreq + 32'd1;
                  if (m_redir) m_stale = 1;
               end
            default: if (inst_data_ok) begin
                  m_phase = 1;
                  if (m_stale || m_redir) begin
                     m_stale = 0;
                     m_ndrop = m_ndrop + 32'd1;
                  end else begin
                     m_cap = 1;
                     m_qpc.push_back(m_req_pc);
                     m_qinst.push_back(mem_word(m_req_pc));
                     m_pc = m_req_pc + 32'd4;
                  end
               end else if (m_redir) begin
                  m_stale = 1;
               end
         endcase
         if (m_redir) begin
            m_pc = m_tgt;
            m_qpc.delete();
            m_qinst.delete();
         end
         m_avail = m_cap;
      end
   end

   task automatic wait_pending();
      int k = 0;
      while (!slv_pend && k < 20) begin
         step();
         k++;
      end
      chk("wait_pending", {31'd0, slv_pend}, 32'd1);
   endtask

   task automatic chk_next_hs(input string nm, input int base, input logic [31:0] exp);
      int k = 0;
      while (hs_log.size() <= base && k < 30) begin
         step();
         k++;
      end
      if (hs_log.size() > base) chk(nm, hs_log[base], exp);
      else chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int base;
      int k;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
      chk("rst_inst_addr", inst_addr, 32'd0);
      chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_fetch_pc", fetch_pc, 32'd0);
      chk("rst_fetch_inst", fetch_inst, 32'd0);
      chk("rst_fetch_available", {31'd0, fetch_available}, 32'd0);
      chk("rst_perf_req", perf_req_cnt, 32'd0);
      chk("rst_perf_drop", perf_drop_cnt, 32'd0);

      // Sequential fetch from the reset vector
      resetn = 1'b1;
      repeat (12) step();
      if (hs_log.size() >= 3) begin
         chk("seq_addr0", hs_log[0], 32'hBFC0_0000);
         chk("seq_addr1", hs_log[1], 32'hBFC0_0004);
         chk("seq_addr2", hs_log[2], 32'hBFC0_0008);
      end else begin
         chk("seq_count", hs_log.size(), 32'd3);
      end

      // Flush and branch together: flush wins
      step();
      inst_addr_ok = 1'b0;
      flush = 1'b1;  flush_pc  = 32'hBFC0_0380;
      br_taken = 1'b1; br_target = 32'h8000_2000;
      base = hs_log.size();
      chk_next_hs("flush_prio", base, 32'hBFC0_0380);
      repeat (6) step();

      // Reset while a response is outstanding
      hold_data = 1;
      wait_pending();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("mid_rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("mid_rst_inst_req", {31'd0, inst_req}, 32'd0);
      chk("mid_rst_avail", {31'd0, fetch_available}, 32'd0);
      hold_data = 0;
      base = hs_log.size();
      chk_next_hs("mid_rst_first_addr", base, RESET_PC);
      repeat (4) step();

      // Branch while waiting; stale data returned three cycles later
      hold_data = 1;
      wait_pending();
      br_taken = 1'b1; br_target = 32'h8000_1000; flush = 1'b0;
      base = hs_log.size();
      step();
      step();
      hold_data = 0;
      chk_next_hs("br_wait_addr", base, 32'h8000_1000);
      repeat (6) step();
`ifdef FETCH_PERF_CNT_EN
      chk("br_wait_drop_cnt", perf_drop_cnt, 32'd1);
`else
      chk("br_wait_drop_cnt", perf_drop_cnt, 32'd0);
`endif

      // Redirect with the address handshake, second redirect a cycle later
      k = 0;
      base = -1;
      while (k < 20 && base < 0) begin
         step();
         inst_addr_ok = 1'b1;
         #1;
         if (inst_req) begin
            br_taken = 1'b1; br_target = 32'h8000_3000;
            base = 0;
         end
         k++;
      end
      chk("dbl_redir_found_req", {31'd0, base == 0}, 32'd1);
      step();
      flush = 1'b0;
      br_taken = 1'b1; br_target = 32'h8000_4000;
      base = hs_log.size();
      chk_next_hs("dbl_redir_addr", base, 32'h8000_4000);
      repeat (6) step();
`ifdef FETCH_PERF_CNT_EN
      chk("dbl_redir_drop_cnt", perf_drop_cnt, 32'd2);
`else
      chk("dbl_redir_drop_cnt", perf_drop_cnt, 32'd0);
`endif

      // Random traffic with occasional resets
      p_aok = 60; p_dok = 50; p_redir = 30;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(2))
               0: p_stall = 0;
               1: p_stall = 40;
               default: p_stall = 90;
            endcase
         end
         step();
         resetn = ($urandom_range(499) != 0);
      end
      step();
      resetn = 1'b1;
      p_redir = 0;
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
